// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, flag bit indices, branch selects and FSM states shared by exec_unit_mc.
package exec_pkg;
  localparam logic [3:0] F_NOP = 4'd0, F_ADD = 4'd1, F_SUB = 4'd2, F_AND = 4'd3, F_OR = 4'd4;
  localparam logic [3:0] F_NOT = 4'd5, F_INC = 4'd6, F_DEC = 4'd7, F_SHL = 4'd8, F_SHR = 4'd9;
  localparam logic [3:0] F_MOV = 4'd10, F_SETC = 4'd11, F_CLRC = 4'd12, F_MUL = 4'd13;
  localparam int FZ = 0, FC = 1, FN = 2;
  localparam logic [1:0] BR_Z = 2'd0, BR_N = 2'd1, BR_C = 2'd2, BR_AL = 2'd3;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/exec_mul_seq.sv
// exec_mul_seq: iterative unsigned shift-add multiplier, one partial product per cycle, DATA_W cycles per product.
module exec_mul_seq #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] prod_lo,
  output logic [DATA_W-1:0] prod_hi
);
  localparam int CW = $clog2(DATA_W);
  logic busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [2*DATA_W-1:0] p_q, p_d;
  logic [DATA_W:0] sum;
  assign busy = busy_q;
  assign done = busy_q && cnt_q == CW'(DATA_W - 1);
  assign prod_lo = p_q[DATA_W-1:0];
  assign prod_hi = p_q[2*DATA_W-1:DATA_W];
  // Multiplier sits in the low half and drains right as partial sums fill the high half.
  always_comb begin
    sum = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, a_q} : '0);
    busy_d = busy_q;
    cnt_d = cnt_q;
    a_d = a_q;
    p_d = p_q;
    if (abort) busy_d = 1'b0;
    else if (start) begin
      busy_d = 1'b1;
      cnt_d = '0;
      a_d = a;
      p_d = {{DATA_W{1'b0}}, b};
    end else if (busy_q) begin
      busy_d = !done;
      cnt_d = cnt_q + CW'(1);
      p_d = {sum, p_q[DATA_W-1:1]};
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      a_q <= '0;
      p_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      p_q <= p_d;
    end
endmodule

// File: rtl/exec_unit_mc.sv
// exec_unit_mc: registered execute stage with Z/C/N flags and branch resolve.
// Define EXEC_MUL_EN to add the multi-cycle unsigned MUL (func 13); otherwise func 13 is a NOP.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        func,
  input  logic              alu_src,
  input  logic              branch,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic              imm_op,
  output logic              branch_taken,
  output logic [2:0]        flags
);
  state_t state_q, state_d;
  logic out_valid_q, out_valid_d, imm_op_q, imm_op_d, branch_taken_q, branch_taken_d;
  logic [DATA_W-1:0] result_q, result_d, result_hi_q, result_hi_d, a, alu_r;
  logic [2:0] flags_q, flags_d, op_flags, br_flags;
  logic [DATA_W:0] sum, dif, shl, shr;
  logic [SHAMT_W-1:0] sh;
  logic [1:0] br_idx;
  logic alu_c, zn_upd, take, accept, mul_start;
  assign in_ready = !reset && state_q == IDLE;
  assign accept = in_valid && in_ready && !flush;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign result_hi = result_hi_q;
  assign imm_op = imm_op_q;
  assign branch_taken = branch_taken_q;
  assign flags = flags_q;
`ifdef EXEC_MUL_EN
  logic mul_busy, mul_done, mul_imm_q, mul_imm_d;
  logic [DATA_W-1:0] mul_lo, mul_hi;
  assign mul_start = accept && !branch && func == F_MUL;
  exec_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk(clk), .reset(reset), .start(mul_start), .abort(flush), .a(a), .b(rd2),
    .busy(mul_busy), .done(mul_done), .prod_lo(mul_lo), .prod_hi(mul_hi)
  );
`else
  assign mul_start = 1'b0;
`endif
  // Shifts run one bit wider so the last bit shifted out lands in the extra position.
  always_comb begin
    a = alu_src ? imm : rd1;
    sh = imm[SHAMT_W-1:0];
    sum = {1'b0, a} + {1'b0, func == F_INC ? DATA_W'(1) : rd2};
    dif = {1'b0, a} - {1'b0, func == F_DEC ? DATA_W'(1) : rd2};
    shl = {1'b0, a} << sh;
    shr = {a, 1'b0} >> sh;
    alu_r = '0;
    alu_c = flags_q[FC];
    case (func)
      F_ADD, F_INC: {alu_c, alu_r} = sum;
      F_SUB, F_DEC: {alu_c, alu_r} = dif;
      F_AND: alu_r = a & rd2;
      F_OR: alu_r = a | rd2;
      F_NOT: alu_r = ~a;
      F_MOV: alu_r = a;
      F_SHL: {alu_c, alu_r} = {sh == '0 ? flags_q[FC] : shl[DATA_W], shl[DATA_W-1:0]};
      F_SHR: {alu_r, alu_c} = {shr[DATA_W:1], sh == '0 ? flags_q[FC] : shr[0]};
      F_SETC: alu_c = 1'b1;
      F_CLRC: alu_c = 1'b0;
      default: ;
    endcase
    zn_upd = func >= F_ADD && func <= F_MOV;
    op_flags = {zn_upd ? alu_r[DATA_W-1] : flags_q[FN], alu_c, zn_upd ? ~|alu_r : flags_q[FZ]};
    br_idx = func[1:0] == BR_Z ? 2'(FZ) : func[1:0] == BR_N ? 2'(FN) : 2'(FC);
    take = func[1:0] == BR_AL || flags_q[br_idx];
    br_flags = flags_q;
    if (take && func[1:0] != BR_AL) br_flags[br_idx] = 1'b0;
  end
  always_comb begin
    state_d = state_q;
    out_valid_d = 1'b0;
    result_d = result_q;
    result_hi_d = result_hi_q;
    flags_d = flags_q;
    branch_taken_d = branch_taken_q;
    imm_op_d = imm_op_q;
`ifdef EXEC_MUL_EN
    mul_imm_d = mul_imm_q;
`endif
    case (state_q)
`ifdef EXEC_MUL_EN
      MUL: state_d = flush || !mul_busy ? IDLE : mul_done ? DONE : MUL;
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          out_valid_d = 1'b1;
          result_d = mul_lo;
          result_hi_d = mul_hi;
          flags_d = {mul_hi[DATA_W-1], |mul_hi, ~|{mul_hi, mul_lo}};
          branch_taken_d = 1'b0;
          imm_op_d = mul_imm_q;
        end
      end
`endif
      default: begin
        if (accept && !mul_start) begin
          out_valid_d = 1'b1;
          result_d = branch ? '0 : alu_r;
          result_hi_d = '0;
          flags_d = branch ? br_flags : op_flags;
          branch_taken_d = branch && take;
          imm_op_d = alu_src;
        end
`ifdef EXEC_MUL_EN
        if (mul_start) begin
          state_d = MUL;
          mul_imm_d = alu_src;
        end
`endif
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      result_q <= '0;
      result_hi_q <= '0;
      flags_q <= '0;
      branch_taken_q <= 1'b0;
      imm_op_q <= 1'b0;
`ifdef EXEC_MUL_EN
      mul_imm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      result_hi_q <= result_hi_d;
      flags_q <= flags_d;
      branch_taken_q <= branch_taken_d;
      imm_op_q <= imm_op_d;
`ifdef EXEC_MUL_EN
      mul_imm_q <= mul_imm_d;
`endif
    end
endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: directed and randomized checks of exec_unit_mc against a transaction-level model.
module tb_exec_unit_mc;
  localparam int W = 16;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, alu_src = 1'b0, branch = 1'b0;
  logic [3:0] func = '0;
  logic [W-1:0] rd1 = '0, rd2 = '0, imm = '0;
  logic in_ready, out_valid, imm_op, branch_taken;
  logic [W-1:0] result, result_hi;
  logic [2:0] flags;

  exec_unit_mc #(.DATA_W(W), .SHAMT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .alu_src(alu_src), .branch(branch), .rd1(rd1), .rd2(rd2), .imm(imm),
    .out_valid(out_valid), .result(result), .result_hi(result_hi), .imm_op(imm_op),
    .branch_taken(branch_taken), .flags(flags)
  );

  always #5 clk = ~clk;

  bit m_busy, m_rst, m_mimm, e_valid, e_br, e_imm;
  int m_cnt, cyc, n_chk, n_fail;
  logic [W-1:0] m_ma, m_mb, e_res, e_hi;
  logic [2:0] e_flags;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Transaction-level reference: what the stage must present after the edge just taken.
  task automatic model_step();
    longint a, b, full;
    int sh;
    logic [W-1:0] r;
    bit c;
    e_valid = 0;
    m_rst = reset;
    if (reset) begin
      m_busy = 0; e_res = '0; e_hi = '0; e_flags = '0; e_br = 0; e_imm = 0;
      return;
    end
    if (m_busy) begin
      m_cnt--;
      if (flush) m_busy = 0;
      else if (m_cnt == 0) begin
        full = longint'(m_ma) * longint'(m_mb);
        e_valid = 1; e_res = full[W-1:0]; e_hi = full[2*W-1:W];
        e_flags = {e_hi[W-1], e_hi != '0, full == 0};
        e_br = 0; e_imm = m_mimm; m_busy = 0;
      end
      return;
    end
    if (!in_valid || flush) return;
    a = longint'(alu_src ? imm : rd1);
    b = longint'(rd2);
    sh = int'(imm[3:0]);
`ifdef EXEC_MUL_EN
    if (!branch && func == 4'd13) begin
      m_busy = 1; m_cnt = W + 1; m_ma = a[W-1:0]; m_mb = b[W-1:0]; m_mimm = alu_src;
      return;
    end
`endif
    e_valid = 1; e_hi = '0; e_imm = alu_src; e_br = 0; e_res = '0;
    if (branch) begin
      case (func[1:0])
        2'd0: e_br = e_flags[0];
        2'd1: e_br = e_flags[2];
        2'd2: e_br = e_flags[1];
        default: e_br = 1;
      endcase
      if (e_br)
        case (func[1:0])
          2'd0: e_flags[0] = 0;
          2'd1: e_flags[2] = 0;
          2'd2: e_flags[1] = 0;
          default: ;
        endcase
      return;
    end
    full = 0;
    c = e_flags[1];
    case (func)
      4'd1: full = a + b;
      4'd2: full = a - b;
      4'd3: full = a & b;
      4'd4: full = a | b;
      4'd5: full = ~a;
      4'd6: full = a + 1;
      4'd7: full = a - 1;
      4'd8: full = a << sh;
      4'd9: full = a >> sh;
      4'd10: full = a;
      default: ;
    endcase
    r = full[W-1:0];
    case (func)
      4'd1, 4'd6: c = full[W];
      4'd2: c = a < b;
      4'd7: c = a == 0;
      4'd8: if (sh != 0) c = full[W];
      4'd9: if (sh != 0) c = ((a >> (sh - 1)) & 1) != 0;
      4'd11: c = 1;
      4'd12: c = 0;
      default: ;
    endcase
    e_flags[1] = c;
    if (func >= 4'd1 && func <= 4'd10) begin
      e_res = r; e_flags[0] = r == '0; e_flags[2] = r[W-1];
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("in_ready", 32'(in_ready), 32'(!reset && !m_busy));
    chk("flags", 32'(flags), 32'(e_flags));
    if (e_valid || m_rst) begin
      chk("result", 32'(result), 32'(e_res));
      chk("result_hi", 32'(result_hi), 32'(e_hi));
      chk("branch_taken", 32'(branch_taken), 32'(e_br));
      chk("imm_op", 32'(imm_op), 32'(e_imm));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic op(input logic [3:0] f, input logic s, input logic br,
                    input logic [W-1:0] r1, input logic [W-1:0] r2, input logic [W-1:0] im);
    func = f; alu_src = s; branch = br; rd1 = r1; rd2 = r2; imm = im; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lat, early;
    tick();
    chk("reset_ready", 32'(in_ready), 32'(0));
    tick();
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'(1));
    op(4'd1, 0, 0, 16'hFFFF, 16'h0001, '0);
    chk("add_valid", 32'(out_valid), 32'(1));
    chk("add_res", 32'(result), 32'h0000);
    chk("add_flags", 32'(flags), 32'b011);
    op(4'd2, 0, 0, 16'h0003, 16'h0005, '0);
    chk("sub_res", 32'(result), 32'hFFFE);
    chk("sub_flags", 32'(flags), 32'b110);
    op(4'd3, 0, 0, 16'h0F0F, 16'h00F0, '0);
    chk("and_res", 32'(result), 32'h0000);
    chk("and_flags", 32'(flags), 32'b011);
    op(4'd0, 0, 1, '0, '0, '0);
    chk("brz_taken", 32'(branch_taken), 32'(1));
    chk("brz_flags", 32'(flags), 32'b010);
    op(4'd0, 0, 1, '0, '0, '0);
    chk("brz_not_taken", 32'(branch_taken), 32'(0));
    chk("brz_flags2", 32'(flags), 32'b010);
`ifdef EXEC_MUL_EN
    op(4'd13, 0, 0, 16'h1234, 16'h0100, '0);
    lat = 0; early = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick();
      if (out_valid) lat = i;
      else if (in_ready) early++;
    end
    chk("mul_latency", 32'(lat), 32'(17));
    chk("mul_ready_low", 32'(early), 32'(0));
    chk("mul_lo", 32'(result), 32'h3400);
    chk("mul_hi", 32'(result_hi), 32'h0012);
    chk("mul_flags", 32'(flags), 32'b010);
    op(4'd13, 0, 0, 16'hFFFF, 16'hFFFF, '0);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_no_valid", 32'(out_valid), 32'(0));
    chk("flush_ready", 32'(in_ready), 32'(1));
    chk("flush_flags", 32'(flags), 32'b010);
    op(4'd13, 0, 0, 16'hFFFF, 16'hFFFF, '0);
    repeat (3) tick();
`else
    op(4'd13, 0, 0, 16'h1234, 16'h0100, '0);
    chk("mul_nop_valid", 32'(out_valid), 32'(1));
    chk("mul_nop_res", 32'(result), 32'h0000);
    chk("mul_nop_hi", 32'(result_hi), 32'h0000);
    chk("mul_nop_flags", 32'(flags), 32'b010);
`endif
    reset = 1'b1;
    tick();
    chk("rst_res", 32'(result), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    reset = 1'b0;
    tick();
    op(4'd1, 0, 0, 16'h0001, 16'h0001, '0);
    chk("b2b_add", 32'(result), 32'h0002);
    op(4'd8, 0, 0, 16'h8000, '0, 16'h0001);
    chk("b2b_shl_valid", 32'(out_valid), 32'(1));
    chk("b2b_shl", 32'(result), 32'h0000);
    chk("b2b_shl_flags", 32'(flags), 32'b011);
    op(4'd11, 0, 0, '0, '0, '0);
    chk("b2b_setc", 32'(flags), 32'b011);
    op(4'd12, 0, 0, '0, '0, '0);
    chk("b2b_clrc_valid", 32'(out_valid), 32'(1));
    chk("b2b_clrc", 32'(flags), 32'b001);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 199) == 0;
      flush = $urandom_range(0, 15) == 0;
      in_valid = $urandom_range(0, 9) < 7;
      func = $urandom_range(0, 5) == 0 ? 4'd13 : 4'($urandom_range(0, 15));
      branch = $urandom_range(0, 4) == 0;
      alu_src = 1'($urandom);
      rd1 = rnd_val();
      rd2 = rnd_val();
      imm = $urandom_range(0, 2) == 0 ? W'($urandom_range(0, 17)) : rnd_val();
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    repeat (20) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
